// File: rtl/oursring_req_rr_arbiter_if.sv
// Handshake bundle between N upstream masters and one downstream port.
// slave: arbiter view (valids/down-readies in; readies, selects, err out).
interface oursring_req_rr_arbiter_if #(
    parameter int N_IN_PORT = 3
);
    logic [N_IN_PORT-1:0] i_awvalid;
    logic [N_IN_PORT-1:0] i_wvalid;
    logic [N_IN_PORT-1:0] i_wlast;
    logic [N_IN_PORT-1:0] i_arvalid;
    logic [N_IN_PORT-1:0] i_awready;
    logic [N_IN_PORT-1:0] i_wready;
    logic [N_IN_PORT-1:0] i_arready;
    logic                 o_awready;
    logic                 o_wready;
    logic                 o_arready;
    logic [N_IN_PORT-1:0] o_aw_sel;
    logic [N_IN_PORT-1:0] o_ar_sel;
    logic                 o_burst_err;

    modport slave (
        input  i_awvalid, i_wvalid, i_wlast, i_arvalid,
        input  o_awready, o_wready, o_arready,
        output i_awready, i_wready, i_arready,
        output o_aw_sel, o_ar_sel, o_burst_err
    );

    modport master (
        output i_awvalid, i_wvalid, i_wlast, i_arvalid,
        output o_awready, o_wready, o_arready,
        input  i_awready, i_wready, i_arready,
        input  o_aw_sel, o_ar_sel, o_burst_err
    );
endinterface

// File: rtl/oursring_req_rr_arbiter.sv
// N-to-1 AW/W/AR handshake arbiter, W bursts locked to owner until wlast.
// Ports: clk, rstn (async active-low), bus (slave modport of the _if).
module oursring_req_rr_arbiter #(
    parameter int N_IN_PORT     = 3,
    parameter bit RR_EN         = 1'b1,
    parameter int MAX_BURST_LEN = 256,
    parameter int CNT_W         = $clog2(MAX_BURST_LEN) + 1
) (
    input logic                     clk,
    input logic                     rstn,
    oursring_req_rr_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_IN_PORT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST_LEN);

    typedef logic [N_IN_PORT-1:0] vec_t;
    typedef logic [PW-1:0]        idx_t;
    typedef enum logic {W_IDLE, W_HOLD} w_state_t;

    // {found, index} of first set bit scanning cyclically from ptr.
    // Reverse loop so the nearest port overwrites farther ones.
    function automatic logic [PW:0] pick(vec_t req, idx_t ptr);
        logic [PW:0] r;
        int          j;
        r = '0;
        for (int k = N_IN_PORT - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_IN_PORT) j -= N_IN_PORT;
            if (req[j]) r = {1'b1, idx_t'(j)};
        end
        return r;
    endfunction

    function automatic idx_t nxt(idx_t i);
        if (!RR_EN) return '0;
        if (int'(i) == N_IN_PORT - 1) return '0;
        return i + idx_t'(1);
    endfunction

    function automatic vec_t oh(idx_t i);
        return vec_t'(1) << i;
    endfunction

    w_state_t         state;
    idx_t             w_ptr;
    idx_t             ar_ptr;
    idx_t             owner;
    logic [CNT_W-1:0] beat_cnt;
    logic             burst_err;

    logic aw_found, ar_found;
    idx_t aw_idx, ar_idx;
    vec_t aw_oh, ar_oh, owner_oh;
    logic aw_go, w_beat, ar_go;

    assign {aw_found, aw_idx} = pick(bus.i_awvalid & bus.i_wvalid, w_ptr);
    assign {ar_found, ar_idx} = pick(bus.i_arvalid, ar_ptr);

    assign aw_oh    = aw_found ? oh(aw_idx) : '0;
    assign ar_oh    = ar_found ? oh(ar_idx) : '0;
    assign owner_oh = oh(owner);

    // AW and first W beat move together, so both downstream readies gate it.
    assign aw_go  = (state == W_IDLE) & aw_found
                  & bus.o_awready & bus.o_wready;
    assign w_beat = (state == W_HOLD) & bus.i_wvalid[owner] & bus.o_wready;
    assign ar_go  = ar_found & bus.o_arready;

    assign bus.o_aw_sel  = (state == W_HOLD) ? owner_oh : aw_oh;
    assign bus.o_ar_sel  = ar_oh;
    assign bus.i_awready = (rstn & aw_go) ? aw_oh : '0;
    assign bus.i_wready  = !rstn  ? '0
                         : aw_go  ? aw_oh
                         : w_beat ? owner_oh
                         : '0;
    assign bus.i_arready = (rstn & ar_go) ? ar_oh : '0;
    assign bus.o_burst_err = burst_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= W_IDLE;
            w_ptr     <= '0;
            ar_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            burst_err <= 1'b0;
            unique case (state)
                W_IDLE: begin
                    if (aw_go) begin
                        if (bus.i_wlast[aw_idx]) begin
                            w_ptr <= nxt(aw_idx);
                        end else begin
                            state    <= W_HOLD;
                            owner    <= aw_idx;
                            beat_cnt <= CNT_W'(1);
                        end
                    end
                end
                W_HOLD: begin
                    if (w_beat) begin
                        if (bus.i_wlast[owner]) begin
                            state    <= W_IDLE;
                            w_ptr    <= nxt(owner);
                            beat_cnt <= '0;
                        end else if (beat_cnt != CNT_MAX) begin
                            // Saturation stops repeat pulses in one burst.
                            beat_cnt  <= beat_cnt + CNT_W'(1);
                            burst_err <= (beat_cnt + CNT_W'(1) == CNT_MAX);
                        end
                    end
                end
                default: state <= W_IDLE;
            endcase
            if (ar_go) ar_ptr <= nxt(ar_idx);
        end
    end

    a_awrdy_oh: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(bus.i_awready));
    a_wrdy_oh: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(bus.i_wready));
    a_arrdy_oh: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(bus.i_arready));
    a_awsel_oh: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(bus.o_aw_sel));
    a_arsel_oh: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(bus.o_ar_sel));
    a_hold_w: assert property (@(posedge clk) disable iff (!rstn)
        (state == W_HOLD) |-> ((bus.i_wready & ~owner_oh) == '0));
endmodule

// File: tb/tb_oursring_req_rr_arbiter.sv
// Bench: RR/MAX=4 instance (a) and fixed-priority instance (b) share stimulus.
// Directed scenarios plus random traffic against a behavioural model.
module tb_oursring_req_rr_arbiter;
    logic clk;
    logic rstn;
    logic [2:0] awvalid, wvalid, wlast, arvalid;
    logic awrdy_d, wrdy_d, arrdy_d;
    int n_cmp = 0;
    int n_bad = 0;

    oursring_req_rr_arbiter_if #(.N_IN_PORT(3)) ifa ();
    oursring_req_rr_arbiter_if #(.N_IN_PORT(3)) ifb ();

    assign ifa.i_awvalid = awvalid;
    assign ifa.i_wvalid  = wvalid;
    assign ifa.i_wlast   = wlast;
    assign ifa.i_arvalid = arvalid;
    assign ifa.o_awready = awrdy_d;
    assign ifa.o_wready  = wrdy_d;
    assign ifa.o_arready = arrdy_d;
    assign ifb.i_awvalid = awvalid;
    assign ifb.i_wvalid  = wvalid;
    assign ifb.i_wlast   = wlast;
    assign ifb.i_arvalid = arvalid;
    assign ifb.o_awready = awrdy_d;
    assign ifb.o_wready  = wrdy_d;
    assign ifb.o_arready = arrdy_d;

    oursring_req_rr_arbiter #(
        .N_IN_PORT(3), .RR_EN(1'b1), .MAX_BURST_LEN(4)
    ) dut_a (.clk(clk), .rstn(rstn), .bus(ifa));

    oursring_req_rr_arbiter #(
        .N_IN_PORT(3), .RR_EN(1'b0), .MAX_BURST_LEN(256)
    ) dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1);
    end

    // ---------------- behavioural reference model ----------------
    bit m_hold[2];
    int m_owner[2], m_wptr[2], m_arptr[2], m_cnt[2];
    bit m_err[2];
    bit rr[2]   = '{1'b1, 1'b0};
    int maxb[2] = '{4, 256};

    function automatic int first_from(logic [2:0] req, int ptr);
        for (int k = 0; k < 3; k++)
            if (req[(ptr + k) % 3]) return (ptr + k) % 3;
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        int c, a, o;
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                m_hold[k] <= 0; m_owner[k] <= 0; m_wptr[k] <= 0;
                m_arptr[k] <= 0; m_cnt[k] <= 0; m_err[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_err[k] <= 0;
                if (!m_hold[k]) begin
                    c = first_from(awvalid & wvalid, m_wptr[k]);
                    if (c >= 0 && awrdy_d && wrdy_d) begin
                        if (wlast[c]) m_wptr[k] <= rr[k] ? (c + 1) % 3 : 0;
                        else begin
                            m_hold[k] <= 1; m_owner[k] <= c; m_cnt[k] <= 1;
                        end
                    end
                end else begin
                    o = m_owner[k];
                    if (wvalid[o] && wrdy_d) begin
                        if (wlast[o]) begin
                            m_hold[k] <= 0;
                            m_wptr[k] <= rr[k] ? (o + 1) % 3 : 0;
                            m_cnt[k] <= 0;
                        end else if (m_cnt[k] < maxb[k]) begin
                            m_cnt[k] <= m_cnt[k] + 1;
                            if (m_cnt[k] + 1 == maxb[k]) m_err[k] <= 1;
                        end
                    end
                end
                a = first_from(arvalid, m_arptr[k]);
                if (a >= 0 && arrdy_d) m_arptr[k] <= rr[k] ? (a + 1) % 3 : 0;
            end
        end
    end

    // {awready, wready, arready, aw_sel, ar_sel, burst_err}
    function automatic logic [15:0] exp_vec(int k);
        logic [2:0] awr, wr, arr, aws, ars;
        int c, a;
        awr = 0; wr = 0; arr = 0;
        if (!m_hold[k]) begin
            c = first_from(awvalid & wvalid, m_wptr[k]);
            aws = (c >= 0) ? 3'(1 << c) : 3'b000;
            if (c >= 0 && awrdy_d && wrdy_d && rstn) begin
                awr = aws; wr = aws;
            end
        end else begin
            aws = 3'(1 << m_owner[k]);
            if (wvalid[m_owner[k]] && wrdy_d && rstn) wr = aws;
        end
        a = first_from(arvalid, m_arptr[k]);
        ars = (a >= 0) ? 3'(1 << a) : 3'b000;
        if (a >= 0 && arrdy_d && rstn) arr = ars;
        return {awr, wr, arr, aws, ars, m_err[k]};
    endfunction

    // ---------------- scenarios ----------------
    task automatic set_in(logic [2:0] aw, logic [2:0] w, logic [2:0] wl,
                          logic [2:0] ar);
        awvalid = aw; wvalid = w; wlast = wl; arvalid = ar;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        set_in(3'b111, 3'b111, 3'b111, 3'b111);
        awrdy_d = 1; wrdy_d = 1; arrdy_d = 1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({ifa.i_awready, ifa.i_wready, ifa.i_arready} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_rdy_a got %b want 0",
                     {ifa.i_awready, ifa.i_wready, ifa.i_arready});
        end
        n_cmp++;
        if ({ifb.i_awready, ifb.i_wready, ifb.i_arready} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_rdy_b got %b want 0",
                     {ifb.i_awready, ifb.i_wready, ifb.i_arready});
        end
        n_cmp++;
        if (ifa.o_burst_err !== 1'b0 || ifa.o_aw_sel !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_state err=%b sel=%b want 0/001",
                     ifa.o_burst_err, ifa.o_aw_sel);
        end
        @(negedge clk);
        set_in(3'b000, 3'b000, 3'b000, 3'b000);
        rstn = 1'b1;
    endtask

    task automatic test_rr_single;
        logic [2:0] e;
        set_in(3'b111, 3'b111, 3'b111, 3'b000);
        for (int i = 0; i < 6; i++) begin
            e = 3'(1 << (i % 3));
            #1;
            n_cmp++;
            if (ifa.i_awready !== e || ifa.i_wready !== e) begin
                n_bad++;
                $display("FAIL rr_single cyc%0d got aw=%b w=%b want %b",
                         i, ifa.i_awready, ifa.i_wready, e);
            end
            n_cmp++;
            if (ifb.i_awready !== 3'b001) begin
                n_bad++;
                $display("FAIL fixed_single cyc%0d got %b want 001",
                         i, ifb.i_awready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_burst_lock;
        set_in(3'b001, 3'b001, 3'b000, 3'b000);
        #1;
        n_cmp++;
        if (ifa.i_awready !== 3'b001) begin
            n_bad++;
            $display("FAIL lock_grant got %b want 001", ifa.i_awready);
        end
        @(negedge clk);
        for (int b = 2; b <= 4; b++) begin
            set_in(3'b010, 3'b011, (b == 4) ? 3'b001 : 3'b000, 3'b000);
            #1;
            n_cmp++;
            if (ifa.i_awready !== 3'b000 || ifa.i_wready !== 3'b001) begin
                n_bad++;
                $display("FAIL lock_beat%0d got aw=%b w=%b want 000/001",
                         b, ifa.i_awready, ifa.i_wready);
            end
            @(negedge clk);
        end
        set_in(3'b010, 3'b010, 3'b010, 3'b000);
        #1;
        n_cmp++;
        if (ifa.i_awready !== 3'b010 || ifa.i_wready !== 3'b010) begin
            n_bad++;
            $display("FAIL lock_next got aw=%b w=%b want 010",
                     ifa.i_awready, ifa.i_wready);
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        set_in(3'b100, 3'b100, 3'b000, 3'b000);
        #1;
        n_cmp++;
        if (ifa.i_awready !== 3'b100) begin
            n_bad++;
            $display("FAIL stall_grant got %b want 100", ifa.i_awready);
        end
        @(negedge clk);
        wrdy_d = 0;
        set_in(3'b001, 3'b101, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ifa.i_wready !== 3'b000 || ifa.i_awready !== 3'b000
                || ifa.o_aw_sel !== 3'b100) begin
                n_bad++;
                $display("FAIL stall cyc%0d got w=%b aw=%b sel=%b want 0/0/100",
                         i, ifa.i_wready, ifa.i_awready, ifa.o_aw_sel);
            end
            @(negedge clk);
        end
        wrdy_d = 1;
        set_in(3'b001, 3'b101, 3'b100, 3'b000);
        #1;
        n_cmp++;
        if (ifa.i_wready !== 3'b100 || ifa.i_awready !== 3'b000) begin
            n_bad++;
            $display("FAIL stall_resume got w=%b aw=%b want 100/000",
                     ifa.i_wready, ifa.i_awready);
        end
        @(negedge clk);
        set_in(3'b001, 3'b001, 3'b001, 3'b000);
        #1;
        n_cmp++;
        if (ifa.i_awready !== 3'b001) begin
            n_bad++;
            $display("FAIL stall_after got %b want 001", ifa.i_awready);
        end
        @(negedge clk);
    endtask

    task automatic test_ar;
        logic [2:0] e;
        set_in(3'b000, 3'b000, 3'b000, 3'b110);
        for (int i = 0; i < 4; i++) begin
            e = (i % 2 == 0) ? 3'b010 : 3'b100;
            #1;
            n_cmp++;
            if (ifa.i_arready !== e || ifa.o_ar_sel !== e) begin
                n_bad++;
                $display("FAIL ar_rr cyc%0d got rdy=%b sel=%b want %b",
                         i, ifa.i_arready, ifa.o_ar_sel, e);
            end
            n_cmp++;
            if (ifb.i_arready !== 3'b010) begin
                n_bad++;
                $display("FAIL ar_fixed cyc%0d got %b want 010",
                         i, ifb.i_arready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_burst_err;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) set_in(3'b010, 3'b010, 3'b000, 3'b000);
            else if (i < 6)
                set_in(3'b000, 3'b010, (i == 5) ? 3'b010 : 3'b000, 3'b000);
            else set_in(3'b000, 3'b000, 3'b000, 3'b000);
            #1;
            n_cmp++;
            if (ifa.o_burst_err !== (i == 4) || ifb.o_burst_err !== 1'b0) begin
                n_bad++;
                $display("FAIL burst_err cyc%0d got a=%b b=%b want %b/0",
                         i, ifa.o_burst_err, ifb.o_burst_err, (i == 4));
            end
            if (i >= 1 && i <= 5) begin
                n_cmp++;
                if (ifa.i_wready !== 3'b010) begin
                    n_bad++;
                    $display("FAIL burst_beat cyc%0d got %b want 010",
                             i, ifa.i_wready);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        set_in(3'b100, 3'b100, 3'b000, 3'b000);
        @(negedge clk);
        set_in(3'b111, 3'b111, 3'b000, 3'b111);
        #1;
        n_cmp++;
        if (ifa.i_wready !== 3'b100 || ifa.i_awready !== 3'b000) begin
            n_bad++;
            $display("FAIL rmid_hold got w=%b aw=%b want 100/000",
                     ifa.i_wready, ifa.i_awready);
        end
        #1;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({ifa.i_awready, ifa.i_wready, ifa.i_arready,
             ifb.i_awready, ifb.i_wready, ifb.i_arready} !== 18'b0) begin
            n_bad++;
            $display("FAIL rmid_drop got %b want 0",
                     {ifa.i_awready, ifa.i_wready, ifa.i_arready,
                      ifb.i_awready, ifb.i_wready, ifb.i_arready});
        end
        @(negedge clk);
        rstn = 1'b1;
        set_in(3'b111, 3'b111, 3'b111, 3'b111);
        #1;
        n_cmp++;
        if (ifa.i_awready !== 3'b001 || ifa.i_wready !== 3'b001
            || ifa.i_arready !== 3'b001) begin
            n_bad++;
            $display("FAIL rmid_after got aw=%b w=%b ar=%b want 001",
                     ifa.i_awready, ifa.i_wready, ifa.i_arready);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [15:0] got, exp;
        for (int i = 0; i < 600; i++) begin
            rstn = ($urandom_range(0, 99) != 0);
            awvalid = 3'($urandom_range(0, 7));
            wvalid  = 3'($urandom_range(0, 7));
            arvalid = 3'($urandom_range(0, 7));
            for (int b = 0; b < 3; b++) wlast[b] = ($urandom_range(0, 2) == 0);
            awrdy_d = ($urandom_range(0, 3) != 0);
            wrdy_d  = ($urandom_range(0, 3) != 0);
            arrdy_d = ($urandom_range(0, 3) != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                exp = exp_vec(k);
                got = (k == 0)
                    ? {ifa.i_awready, ifa.i_wready, ifa.i_arready,
                       ifa.o_aw_sel, ifa.o_ar_sel, ifa.o_burst_err}
                    : {ifb.i_awready, ifb.i_wready, ifb.i_arready,
                       ifb.o_aw_sel, ifb.o_ar_sel, ifb.o_burst_err};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL random inst%0d cyc%0d got %b want %b",
                             k, i, got, exp);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_rr_single();
        test_burst_lock();
        test_stall();
        test_ar();
        test_burst_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/oursring_req_rr_arbiter.md
Name: oursring_req_rr_arbiter

Overview:
- N-to-1 request-channel arbiter for the oursring fabric. It merges the AW, W and AR handshakes of N_IN_PORT masters onto one downstream port.
- Fairness is selectable: round-robin or fixed priority. W bursts are locked to their owner until wlast.
- Exports one-hot select vectors so the parent can mux payloads. Flags W bursts that exceed the configured maximum length.
- Handshake-only: no payload buses pass through this block.

Parameters:
- N_IN_PORT, 3, number of upstream master ports (≥2).
- RR_EN, 1, 1 = round-robin per channel group, 0 = fixed priority with lowest index winning.
- MAX_BURST_LEN, 256, W beats per burst allowed before o_burst_err fires (≥2).
- CNT_W, $clog2(MAX_BURST_LEN)+1, width of the beat counter (derived).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous assert, active-low
- i_awvalid  in  N_IN_PORT  upstream AW valid
- i_wvalid  in  N_IN_PORT  upstream W valid
- i_wlast  in  N_IN_PORT  upstream W last beat
- i_arvalid  in  N_IN_PORT  upstream AR valid
- i_awready  out  N_IN_PORT  upstream AW ready, at most one hot
- i_wready  out  N_IN_PORT  upstream W ready, at most one hot
- i_arready  out  N_IN_PORT  upstream AR ready, at most one hot
- o_awready  in  1  downstream AW ready
- o_wready  in  1  downstream W ready
- o_arready  in  1  downstream AR ready
- o_aw_sel  out  N_IN_PORT  one-hot AW/W payload select, 0 when no candidate
- o_ar_sel  out  N_IN_PORT  one-hot AR payload select, 0 when no candidate
- o_burst_err  out  1  one-cycle pulse when a burst reaches MAX_BURST_LEN beats without wlast

Behaviour:
- Reset (rstn=0, async):
  - State goes to W_IDLE; w_ptr=0, ar_ptr=0, owner=0, beat_cnt=0, o_burst_err=0.
  - All i_*ready are forced to 0 while rstn=0, even if valids are high.
  - Reset mid-burst abandons the burst. No recovery beat is issued.
- Candidate search:
  - Scan ports cyclically from the pointer (ptr, ptr+1, … wrapping at N_IN_PORT-1→0). The first port meeting the condition wins.
  - With RR_EN=0 the pointers stay at 0 permanently.
- AW/W state machine, states W_IDLE and W_HOLD:
  - W_IDLE:
    - Candidate c is the first port with i_awvalid[c] & i_wvalid[c]. o_aw_sel = onehot(c), independent of the ready inputs.
    - i_awready[c] = i_wready[c] = o_awready & o_wready. AW and first W beat must transfer in the same cycle.
    - On handshake with i_wlast[c]=1: stay in W_IDLE; w_ptr ← (c+1) mod N.
    - On handshake with i_wlast[c]=0: go to W_HOLD; owner ← c; beat_cnt ← 1.
    - A port with only awvalid or only wvalid is never granted.
  - W_HOLD:
    - o_aw_sel = onehot(owner). All i_awready = 0.
    - i_wready[owner] = i_wvalid[owner] ? o_wready : 0. Other ports' W readies are 0.
    - Each beat (i_wvalid & i_wready): beat_cnt++, saturating at MAX_BURST_LEN.
    - Beat with wlast: go to W_IDLE; w_ptr ← (owner+1) mod N; beat_cnt ← 0.
    - A wlast beat returns to W_IDLE with zero bubble. A new grant is possible the next cycle.
    - When beat_cnt increments to MAX_BURST_LEN without wlast: o_burst_err=1 for that following cycle only. The lock is kept; the burst continues until wlast and no further pulse fires for that burst.
  - The pointer advances only on burst completion, never on a stalled or in-progress burst.
- AR channel, independent of AW/W and concurrent with them:
  - Candidate a is the first port with i_arvalid from ar_ptr. o_ar_sel = onehot(a).
  - i_arready[a] = o_arready.
  - On handshake, ar_ptr ← (a+1) mod N. Otherwise ar_ptr holds.
- Latency and timing:
  - All readies and selects are combinational from the valids, the downstream readies and registered state. Zero-cycle grant latency.
  - No combinational path from i_*ready back to any i_*valid.
- Simultaneous events:
  - AR grant and AW/W grant in the same cycle are both allowed.
  - Valids dropping while un-granted are tolerated.
  - A stalled W_HOLD owner (wvalid=0) blocks every other writer.
- Invariants (assertions, non-synthesis):
  - Each ready vector is onehot0.
  - Each *_sel vector is onehot0.
  - In W_HOLD, i_wready is a subset of onehot(owner).

Test Plan:
- RR_EN=1, N=3, all ports issue single-beat writes (wlast=1) continuously, downstream always ready → grants cycle 0,1,2,0,1,2 on consecutive cycles.
- Port 0 issues a 4-beat burst; port 1 asserts AW+W during beat 2 → port 1 is granted only in the cycle after port 0's wlast beat. Port 1's i_awready stays 0 during port 0's beats 1–4.
- Downstream o_wready=0 for 3 cycles mid-burst → no beat counted, w_ptr unchanged, owner held. The burst completes after o_wready returns to 1.
- RR_EN=0, ports 1 and 2 hold arvalid continuously → port 1 is always granted and port 2 is starved. With RR_EN=1 the grants alternate 1,2,1,2.
- MAX_BURST_LEN=4, a 6-beat burst → o_burst_err pulses once in the cycle after beat 4, and the burst still completes at beat 6.
- Assert rstn low during W_HOLD with valids held high → all readies drop immediately. After release, state is W_IDLE and w_ptr=0, so port 0 is granted first.
